exception_sequencer: RTL
========================

Name: exception_sequencer

Overview:
- Multi-cycle sequencer directly downstream of the interrupt controller.
- On `jisr` it snapshots machine state and writes EPC, ECA, EDATA, ESR and then SR into the SPR file through one write port. It then redirects the PC to the exception vector.
- On `eret` it restores SR from ESR and returns to EPC.
- It stalls the pipeline for the whole sequence.

Parameters:
- VECTOR_ADDR, 32'h0000_0000, PC loaded on exception entry.
- SR_CLEAR, 32'h0000_0000, value written to SR on entry (masks all interrupts).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- jisr  in  1  jump-to-interrupt-service request from the interrupt controller.
- il  in  5  interrupt level of the winning cause.
- mca  in  23  masked cause vector.
- eret  in  1  return-from-exception instruction in execute.
- rpt  in  1  1 = repeat the interrupted instruction (save pc), 0 = continue (save next_pc).
- pc  in  32  current instruction address.
- next_pc  in  32  address of the following instruction.
- ea  in  32  effective address of the faulting load/store.
- sr  in  32  current status register.
- esr  in  32  current saved status register.
- epc  in  32  current saved PC.
- mode  in  1  current mode (1 = user, 0 = system).
- stall  out  1  freeze the pipeline.
- busy  out  1  FSM not in IDLE.
- spr_we  out  1  SPR write enable.
- spr_addr  out  3  SPR index: SR=0, ESR=1, ECA=2, EPC=3, EDATA=4.
- spr_wdata  out  32  SPR write data.
- pc_load  out  1  one-cycle PC redirect strobe.
- pc_target  out  32  redirect address, valid when pc_load=1.
- mode_out  out  1  mode to apply to the pipeline.

Behaviour:
- States:
  - Entry path: IDLE, S_EPC, S_ECA, S_EDATA, S_ESR, S_SR, VEC.
  - Return path: R_SR, RET.
- IDLE:
  - jisr=1: capture snapshot registers, then go to S_EPC. The snapshot holds save_pc = rpt ? pc : next_pc, eca = {il, 4'b0, mca}, ea, sr, and emode = mode.
  - else eret=1: go to R_SR.
  - jisr has priority over eret when both are high in the same cycle.
- Entry path, one state per cycle:
  - S_EPC writes EPC = save_pc.
  - S_ECA writes ECA = eca.
  - S_EDATA writes EDATA = ea.
  - S_ESR writes ESR = snapshot sr.
  - S_SR writes SR = SR_CLEAR.
  - VEC: pc_load=1, pc_target=VECTOR_ADDR, mode_out<=0, then IDLE.
- Return path:
  - R_SR writes SR = esr as sampled in R_SR.
  - RET: pc_load=1, pc_target=epc, mode_out<=emode, then IDLE.
- SPR writes are registered: spr_we, spr_addr and spr_wdata are valid during the named state. spr_we=0 in IDLE, VEC and RET.
- stall:
  - Combinational: 1 in IDLE when jisr|eret.
  - 1 in every non-IDLE state.
  - 0 otherwise.
- Latency:
  - Entry: 7 cycles from jisr accept to pc_load, counting the accept cycle.
  - Return: 3 cycles.
- busy = (state != IDLE).
- jisr and eret are ignored outside IDLE; no queuing. The controller re-asserts jisr if the cause persists.
- Snapshot values are frozen for the whole sequence. Input changes after acceptance have no effect.
- mode_out changes only in VEC and RET, otherwise it holds.
- An eret while mode=1 is not filtered here; the illegal-instruction check lives upstream.
- Reset (any state, including mid-sequence):
  - state=IDLE, mode_out=0, spr_we=0, pc_load=0, spr_addr=0, spr_wdata=0, pc_target=0, busy=0.
  - The partial SPR sequence is abandoned and no further writes occur.
- Back-to-back events:
  - A jisr present in the cycle after VEC or RET (state is IDLE) is accepted immediately.
  - No dead cycle is required.

Test Plan:
- Reset, then idle → all outputs 0, stall=0, mode_out=0.
- mode=1, pc=0x100, next_pc=0x104, rpt=0, il=5, mca=0x000010, ea=0x2002, sr=0xFF, jisr=1 for one cycle → the following write sequence, then:
  - EPC=0x104
  - ECA=0x2800_0010
  - EDATA=0x2002
  - ESR=0xFF
  - SR=0
  - pc_load=1 with pc_target=0 on the 7th cycle, mode_out=0.
  - stall high for exactly 7 cycles.
- Same stimulus with rpt=1 → EPC write = 0x100.
- After entry from mode=1: esr=0xFF, epc=0x104, eret=1 → SR write 0xFF, then pc_load with pc_target=0x104, mode_out=1, total 3 cycles.
- jisr and eret both high in IDLE → the entry path runs and no R_SR write occurs. Pulsing jisr again during S_ECA → ignored; exactly one EPC write.
- Assert reset during S_EDATA → next cycle IDLE with spr_we=0. No ESR/SR writes and no pc_load follow. A new jisr afterwards runs the full 7-cycle sequence.

Source files
------------

// File: rtl/exception_sequencer_if.sv
// Exception sequencer bus: interrupt-controller / pipeline inputs and the
// SPR write port, PC redirect and mode outputs of the sequencer.
interface exception_sequencer_if;
   // Requests and machine state from the interrupt controller and pipeline
   logic        jisr;
   logic [4:0]  il;
   logic [22:0] mca;
   logic        eret;
   logic        rpt;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic [31:0] ea;
   logic [31:0] sr;
   logic [31:0] esr;
   logic [31:0] epc;
   logic        mode;

   // Sequencer results
   logic        stall;
   logic        busy;
   logic        spr_we;
   logic [2:0]  spr_addr;
   logic [31:0] spr_wdata;
   logic        pc_load;
   logic [31:0] pc_target;
   logic        mode_out;

   // Pipeline / interrupt-controller side
   modport master (
      output jisr, il, mca, eret, rpt, pc, next_pc, ea, sr, esr, epc, mode,
      input  stall, busy, spr_we, spr_addr, spr_wdata, pc_load, pc_target, mode_out
   );

   // Sequencer side
   modport slave (
      input  jisr, il, mca, eret, rpt, pc, next_pc, ea, sr, esr, epc, mode,
      output stall, busy, spr_we, spr_addr, spr_wdata, pc_load, pc_target, mode_out
   );
endinterface

// File: rtl/exception_sequencer.sv
// Exception entry/return sequencer. On jisr it snapshots machine state and
// writes EPC, ECA, EDATA, ESR and SR through the single SPR write port, then
// redirects to the vector. On eret it restores SR from ESR and returns to EPC.
// The pipeline is stalled for the whole sequence.
module exception_sequencer #(
   parameter logic [31:0] VECTOR_ADDR = 32'h0000_0000,
   parameter logic [31:0] SR_CLEAR    = 32'h0000_0000
) (
   input logic                  clk,
   input logic                  reset,
   exception_sequencer_if.slave bus
);

   // SPR file indices
   localparam logic [2:0] SprSr    = 3'd0;
   localparam logic [2:0] SprEsr   = 3'd1;
   localparam logic [2:0] SprEca   = 3'd2;
   localparam logic [2:0] SprEpc   = 3'd3;
   localparam logic [2:0] SprEdata = 3'd4;

   typedef enum logic [3:0] {
      StIdle,
      StEpc,
      StEca,
      StEdata,
      StEsr,
      StSr,
      StVec,
      StRsr,
      StRet
   } state_e;

   state_e      r_state;
   state_e      w_state_next;

   // Snapshot taken when jisr is accepted; frozen until the next acceptance
   logic [31:0] r_save_pc;
   logic [31:0] r_eca;
   logic [31:0] r_ea;
   logic [31:0] r_sr;
   logic        r_emode;

   // Mode currently applied to the pipeline
   logic        r_mode;

   logic        w_idle;
   logic        w_accept_jisr;
   logic        w_accept_eret;

   logic        w_stall;
   logic        w_spr_we;
   logic [2:0]  w_spr_addr;
   logic [31:0] w_spr_wdata;
   logic        w_pc_load;
   logic [31:0] w_pc_target;
   logic        w_mode_out;

   assign w_idle        = (r_state == StIdle);
   // jisr wins over eret when both arrive together
   assign w_accept_jisr = w_idle & bus.jisr;
   assign w_accept_eret = w_idle & ~bus.jisr & bus.eret;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state: entry path steps one SPR per cycle, return path is two steps
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_accept_jisr) begin
               w_state_next = StEpc;
            end else if (w_accept_eret) begin
               w_state_next = StRsr;
            end
         end
         StEpc:   w_state_next = StEca;
         StEca:   w_state_next = StEdata;
         StEdata: w_state_next = StEsr;
         StEsr:   w_state_next = StSr;
         StSr:    w_state_next = StVec;
         StVec:   w_state_next = StIdle;
         StRsr:   w_state_next = StRet;
         StRet:   w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Snapshot capture on jisr acceptance only
   always_ff @(posedge clk) begin
      if (reset) begin
         r_save_pc <= '0;
         r_eca     <= '0;
         r_ea      <= '0;
         r_sr      <= '0;
         r_emode   <= 1'b0;
      end else if (w_accept_jisr) begin
         r_save_pc <= bus.rpt ? bus.pc : bus.next_pc;
         r_eca     <= {bus.il, 4'b0000, bus.mca};
         r_ea      <= bus.ea;
         r_sr      <= bus.sr;
         r_emode   <= bus.mode;
      end
   end

   // Outputs decoded from the registered state and snapshot
   always_comb begin
      w_stall     = 1'b1;
      w_spr_we    = 1'b0;
      w_spr_addr  = '0;
      w_spr_wdata = '0;
      w_pc_load   = 1'b0;
      w_pc_target = '0;
      w_mode_out  = r_mode;
      unique case (r_state)
         StIdle: begin
            w_stall = bus.jisr | bus.eret;
         end
         StEpc: begin
            w_spr_we    = 1'b1;
            w_spr_addr  = SprEpc;
            w_spr_wdata = r_save_pc;
         end
         StEca: begin
            w_spr_we    = 1'b1;
            w_spr_addr  = SprEca;
            w_spr_wdata = r_eca;
         end
         StEdata: begin
            w_spr_we    = 1'b1;
            w_spr_addr  = SprEdata;
            w_spr_wdata = r_ea;
         end
         StEsr: begin
            w_spr_we    = 1'b1;
            w_spr_addr  = SprEsr;
            w_spr_wdata = r_sr;
         end
         StSr: begin
            w_spr_we    = 1'b1;
            w_spr_addr  = SprSr;
            w_spr_wdata = SR_CLEAR;
         end
         StVec: begin
            w_pc_load   = 1'b1;
            w_pc_target = VECTOR_ADDR;
            w_mode_out  = 1'b0;
         end
         StRsr: begin
            // ESR is taken live here, not from the entry snapshot
            w_spr_we    = 1'b1;
            w_spr_addr  = SprSr;
            w_spr_wdata = bus.esr;
         end
         StRet: begin
            w_pc_load   = 1'b1;
            w_pc_target = bus.epc;
            w_mode_out  = r_emode;
         end
         default: begin
            w_stall = 1'b0;
         end
      endcase
   end

   // Mode holds between VEC/RET, which are the only states that change it
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mode <= 1'b0;
      end else begin
         r_mode <= w_mode_out;
      end
   end

   assign bus.stall     = w_stall;
   assign bus.busy      = ~w_idle;
   assign bus.spr_we    = w_spr_we;
   assign bus.spr_addr  = w_spr_addr;
   assign bus.spr_wdata = w_spr_wdata;
   assign bus.pc_load   = w_pc_load;
   assign bus.pc_target = w_pc_target;
   assign bus.mode_out  = w_mode_out;

   // Redirect strobe is a single-cycle pulse
   a_pc_load_pulse: assert property (@(posedge clk) disable iff (reset)
      w_pc_load |=> !w_pc_load);

   // No SPR write and redirect in the same cycle
   a_we_load_excl: assert property (@(posedge clk) disable iff (reset)
      !(w_spr_we && w_pc_load));

endmodule
